uart_command_rx: RTL and testbench



---
 rtl/uart_command_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_command_rx.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_command_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_command_rx
// Purpose  : 8N1 UART receiver (LSB first) for remote control of the
//            card-flip game. Received ASCII characters are decoded into
//            single-cycle button pulses. The raw byte stream, error strobes
//            and a saturating error counter are also exposed.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   uart_rx      in   serial line, idle high, asynchronous to clk
//   up_pulse     out  one-cycle pulse on 'U'/'u'
//   down_pulse   out  one-cycle pulse on 'D'/'d'
//   left_pulse   out  one-cycle pulse on 'L'/'l'
//   right_pulse  out  one-cycle pulse on 'R'/'r'
//   select_pulse out  one-cycle pulse on 'S'/'s'/space
//   rx_data      out  last correctly framed byte
//   rx_valid     out  one-cycle strobe, rx_data updated
//   frame_err    out  one-cycle strobe, stop bit sampled low
//   cmd_err      out  one-cycle strobe, framed byte is not a command
//   err_count    out  saturating count of frame_err + cmd_err events
// ============================================================================
module uart_command_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       left_pulse,
  output logic       right_pulse,
  output logic       select_pulse,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       cmd_err,
  output logic [7:0] err_count
);

  localparam int                C_CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [C_CNT_W-1:0] C_HALF_LAST = C_CNT_W'((CLKS_PER_BIT / 2) - 1);
  localparam logic [C_CNT_W-1:0] C_BIT_LAST  = C_CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Input synchroniser; flops reset to the idle (high) line level so that
  // leaving reset never looks like a start edge.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      rx_prev_q <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  state_t               state_q,  state_d;
  logic [C_CNT_W-1:0]   baud_q,   baud_d;
  logic [2:0]           bit_q,    bit_d;
  logic [7:0]           shift_q,  shift_d;
  logic [7:0]           data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic                 ferr_q,   ferr_d;
  logic                 cerr_q,   cerr_d;
  logic                 up_q,     up_d;
  logic                 down_q,   down_d;
  logic                 left_q,   left_d;
  logic                 right_q,  right_d;
  logic                 sel_q,    sel_d;
  logic [7:0]           err_q,    err_d;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + C_CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    cerr_d  = 1'b0;
    up_d    = 1'b0;
    down_d  = 1'b0;
    left_d  = 1'b0;
    right_d = 1'b0;
    sel_d   = 1'b0;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        // Counter held at zero so it starts from 0 the cycle after the edge.
        baud_d = '0;
        if (rx_prev_q && !rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_q == C_HALF_LAST) begin
          baud_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end
        end
      end

      S_DATA: begin
        if (baud_q == C_BIT_LAST) begin
          baud_d  = '0;
          // Shift in from the top: after eight samples the first bit
          // received sits in bit 0 (LSB-first line order).
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (baud_q == C_BIT_LAST) begin
          baud_d = '0;
          if (rx_s) begin
            // Return to IDLE at mid-stop so a start bit that immediately
            // follows the stop bit is caught.
            state_d = S_IDLE;
            valid_d = 1'b1;
            data_d  = shift_q;
            case (shift_q)
              8'h55, 8'h75:        up_d    = 1'b1;
              8'h44, 8'h64:        down_d  = 1'b1;
              8'h4C, 8'h6C:        left_d  = 1'b1;
              8'h52, 8'h72:        right_d = 1'b1;
              8'h53, 8'h73, 8'h20: sel_d   = 1'b1;
              8'h0D, 8'h0A:        ;
              default:             cerr_d  = 1'b1;
            endcase
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        // A held-low line yields a single frame error; wait for idle level.
        baud_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase

    if ((ferr_d || cerr_d) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      cerr_q  <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      sel_q   <= 1'b0;
      err_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      cerr_q  <= cerr_d;
      up_q    <= up_d;
      down_q  <= down_d;
      left_q  <= left_d;
      right_q <= right_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign up_pulse     = up_q;
  assign down_pulse   = down_q;
  assign left_pulse   = left_q;
  assign right_pulse  = right_q;
  assign select_pulse = sel_q;
  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign frame_err    = ferr_q;
  assign cmd_err      = cerr_q;
  assign err_count    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_command_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_command_rx
// Purpose  : Self-checking bench for uart_command_rx. Frames are driven on
//            the serial line, a reference model predicts every strobe event
//            (cycle, flags, data, error count) and a monitor records what the
//            design actually produced.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_command_rx;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
  // Drive of start bit -> first cycle the registered strobes are visible.
  localparam int LAT  = SYNC + CPB / 2 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       up_pulse, down_pulse, left_pulse, right_pulse, select_pulse;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, cmd_err;
  logic [7:0] err_count;

  uart_command_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .up_pulse    (up_pulse),
    .down_pulse  (down_pulse),
    .left_pulse  (left_pulse),
    .right_pulse (right_pulse),
    .select_pulse(select_pulse),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .cmd_err     (cmd_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int asserts = 0;
  int fails   = 0;

  // Event = {cycle, valid, ferr, cerr, up, down, left, right, sel, data, errcnt}
  typedef logic [55:0] ev_t;
  ev_t got_q[$];
  ev_t exp_q[$];

  logic [7:0] m_data;
  int         m_err;

  always @(negedge clk) begin
    if (rx_valid | frame_err | cmd_err | up_pulse | down_pulse |
        left_pulse | right_pulse | select_pulse)
      got_q.push_back({32'(cyc), rx_valid, frame_err, cmd_err, up_pulse,
                       down_pulse, left_pulse, right_pulse, select_pulse,
                       rx_data, err_count});
  end

  // Command table from the character set: letters folded to upper case.
  function automatic logic [4:0] cmd_of(input logic [7:0] b);
    logic [7:0] u;
    u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    if (b == 8'h20) return 5'b00001;
    case (u)
      8'h55:   return 5'b10000;
      8'h44:   return 5'b01000;
      8'h4C:   return 5'b00100;
      8'h52:   return 5'b00010;
      8'h53:   return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic model_frame(input logic [7:0] b, input bit ok, input int c0);
    logic [4:0] p;
    bit         fe, ce;
    p  = ok ? cmd_of(b) : 5'b00000;
    fe = !ok;
    ce = ok && (p == 5'b00000) && (b != 8'h0D) && (b != 8'h0A);
    if (ok) m_data = b;
    if ((fe || ce) && m_err < 255) m_err++;
    exp_q.push_back({32'(c0 + LAT), ok, fe, ce, p, m_data, 8'(m_err)});
  endtask

  // All line tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok);
    logic [9:0] bits;
    int         c0;
    bits = {ok, b, 1'b0};
    c0   = cyc;
    model_frame(b, ok, c0);
    for (int k = 0; k < 10; k++) begin
      uart_rx = bits[k];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    asserts++;
    if ({rx_valid, frame_err, cmd_err, up_pulse, down_pulse, left_pulse,
         right_pulse, select_pulse} !== 8'h00) begin
      fails++;
      $display("FAIL reset_strobes: got %b required 00000000",
               {rx_valid, frame_err, cmd_err, up_pulse, down_pulse,
                left_pulse, right_pulse, select_pulse});
    end
    asserts++;
    if (rx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_rx_data: got %h required 00", rx_data);
    end
    asserts++;
    if (err_count !== 8'h00) begin
      fails++;
      $display("FAIL reset_err_count: got %h required 00", err_count);
    end
    reset  = 1'b0;
    m_data = 8'h00;
    m_err  = 0;
    idle(10);
  endtask

  task automatic test_up;
    send_frame(8'h55, 1'b1);
    idle(4);
    asserts++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL up_count: got %0d events required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      asserts++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL up_event[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [5];
    seq = '{8'h64, 8'h6C, 8'h72, 8'h73, 8'h20};
    foreach (seq[i]) send_frame(seq[i], 1'b1);
    idle(4);
    asserts++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL b2b_count: got %0d events required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      asserts++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL b2b_event[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_cmd_err_and_crlf;
    send_frame(8'h41, 1'b1);
    idle(7);
    send_frame(8'h0D, 1'b1);
    send_frame(8'h0A, 1'b1);
    idle(4);
    asserts++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL cmderr_count: got %0d events required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      asserts++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL cmderr_event[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_frame_err;
    send_frame(8'h53, 1'b0);
    idle(10);
    asserts++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL frameerr_count: got %0d events required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      asserts++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL frameerr_event[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_break;
    int c0;
    c0 = cyc;
    model_frame(8'h00, 1'b0, c0);
    uart_rx = 1'b0;
    repeat (40 * CPB) @(posedge clk);
    #1;
    idle(20);
    send_frame(8'h55, 1'b1);
    idle(4);
    asserts++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL break_count: got %0d events required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      asserts++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL break_event[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_glitch;
    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(3 * CPB);
    send_frame(8'h4C, 1'b1);
    idle(4);
    asserts++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL glitch_count: got %0d events required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      asserts++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL glitch_event[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    // Start bit, then 0x52's first bits; reset lands inside the data field.
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    m_data = 8'h00;
    m_err  = 0;
    asserts++;
    if ({rx_data, err_count} !== 16'h0000) begin
      fails++;
      $display("FAIL midreset_state: got data %h errcnt %h required 00 00", rx_data, err_count);
    end
    idle(5 * CPB);
    send_frame(8'h52, 1'b1);
    idle(4);
    asserts++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL midreset_count: got %0d events required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      asserts++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL midreset_event[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random;
    logic [7:0] cmds [11];
    logic [7:0] b;
    bit         ok;
    cmds = '{8'h55, 8'h75, 8'h44, 8'h64, 8'h4C, 8'h6C, 8'h52, 8'h72, 8'h53, 8'h73, 8'h20};
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) b = cmds[$urandom_range(0, 10)];
      else                           b = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok);
      idle(ok ? $urandom_range(0, 20) : $urandom_range(4, 20));
    end
    idle(4);
    asserts++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL random_count: got %0d events required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      asserts++;
      if (got_q[i] !== exp_q[i] || $countones(got_q[i][20:16]) > 1) begin
        fails++;
        $display("FAIL random_event[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_saturation;
    for (int n = 0; n < 260; n++) send_frame(8'h7E, 1'b1);
    idle(4);
    asserts++;
    if (err_count !== 8'hFF) begin
      fails++;
      $display("FAIL sat_err_count: got %h required ff", err_count);
    end
    asserts++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL sat_count: got %0d events required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      asserts++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL sat_event[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_up();
    test_back_to_back();
    test_cmd_err_and_crlf();
    test_frame_err();
    test_break();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire
